// File: rtl/cv32e41s_pkg.sv
// Shared OBI data-side types and constants for the cv32e41s integrity responders.
package cv32e41s_pkg;

    localparam int unsigned RCHK_W = 5;

    typedef struct packed {
        logic [31:0]       rdata;
        logic              err;
        logic              exokay;
        logic [RCHK_W-1:0] rchk;
        logic              integrity;
    } obi_data_resp_t;

endpackage

// File: rtl/cv32e41s_rchk_gen.sv
// Response checksum generator: per-byte parity of rdata plus parity of {err, exokay=0}.
module cv32e41s_rchk_gen
    import cv32e41s_pkg::*;
(
    input  logic [31:0]       rdata,
    input  logic              err,
    output logic [RCHK_W-1:0] rchk
);

    always_comb begin
        rchk = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            rchk[i] = ^rdata[8*i +: 8];
        end
        rchk[4] = ^{err, 1'b0};
    end

endmodule

// File: rtl/cv32e41s_obi_rchk_responder.sv
// OBI data responder fronting a 1-cycle SRAM port; buffers responses and attaches rchk.
module cv32e41s_obi_rchk_responder
    import cv32e41s_pkg::*;
#(
    parameter int unsigned DEPTH     = 3,
    parameter logic        INTEGRITY = 1'b1,
    parameter type         RESP_TYPE = obi_data_resp_t
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       addr_i,
    input  logic              we_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output RESP_TYPE          resp_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_err_i,
    input  logic [RCHK_W-1:0] rchk_flip_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  fifo_cnt_q;
    logic              inflight_q;
    logic              we_q;
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [31:0]       rdata_q [DEPTH];
    logic              err_q   [DEPTH];

    logic              accept;
    logic              push;
    logic              pop;
    logic [31:0]       head_rdata;
    logic              head_err;
    logic [RCHK_W-1:0] head_rchk;

    // Grant depends only on registered credit state, never on rready_i.
    assign gnt_o       = req_i && (cnt_q < CNT_W'(DEPTH));
    assign accept      = req_i && gnt_o;

    assign mem_req_o   = accept;
    assign mem_we_o    = we_i;
    assign mem_addr_o  = addr_i;
    assign mem_be_o    = be_i;
    assign mem_wdata_o = wdata_i;

    assign push        = inflight_q;
    assign rvalid_o    = (fifo_cnt_q != '0);
    assign pop         = rvalid_o && rready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            fifo_cnt_q <= '0;
            inflight_q <= 1'b0;
            we_q       <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            cnt_q      <= cnt_q + CNT_W'(accept) - CNT_W'(pop);
            fifo_cnt_q <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
            inflight_q <= accept;
            if (accept) begin
                we_q <= we_i;
            end
            if (push) begin
                wptr_q <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: resp_o is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            rdata_q[wptr_q] <= we_q ? 32'h0 : mem_rdata_i;
            err_q[wptr_q]   <= mem_err_i;
        end
    end

    assign head_rdata = rdata_q[rptr_q];
    assign head_err   = err_q[rptr_q];

    cv32e41s_rchk_gen u_rchk_gen (
        .rdata (head_rdata),
        .err   (head_err),
        .rchk  (head_rchk)
    );

    always_comb begin
        resp_o = '0;
        if (rvalid_o) begin
            resp_o.rdata     = head_rdata;
            resp_o.err       = head_err;
            resp_o.exokay    = 1'b0;
            resp_o.rchk      = head_rchk ^ rchk_flip_i;
            resp_o.integrity = INTEGRITY;
        end
    end

`ifndef SYNTHESIS
    a_cnt_max : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= CNT_W'(DEPTH));
    a_cnt_sum : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q == CNT_W'(inflight_q) + fifo_cnt_q);
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (fifo_cnt_q < CNT_W'(DEPTH)));
    a_resp_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (rvalid_o && !rready_i) |=> $stable(resp_o));
    a_req_gnt : assert property (@(posedge clk) disable iff (!rst_n)
        mem_req_o |-> gnt_o);
`endif

endmodule
